// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 single-wire reader.
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_LOW,
        ST_RELEASE,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_DONE
    } state_e;

    // Returned on a line timeout; its checksum byte cannot match the data bytes.
    localparam logic [39:0] ERR_FRAME = 40'h00_0000_00FF;

    function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned us);
        return (clk_hz / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/dht11_sync_edge.sv
// Two-flop synchronizer for the DHT11 pad, with registered rise/fall pulses.
module dht11_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, s3_q;
    logic rise_q, fall_q;

    // Preset high so an idle pulled-up line produces no edge out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            s3_q   <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= din_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
            fall_q <= ~s2_q & s3_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/dht11_reader.sv
// DHT11 transaction engine: start pulse, sensor response, 40 raw data bits.
// state      | meaning
// IDLE       | waiting for start_dht11
// START_LOW  | host holds the line low
// RELEASE    | line released, waiting for sensor to pull low
// RESP_LOW   | sensor response low phase
// RESP_HIGH  | sensor response high phase
// BIT_LOW    | low gap before a data bit
// BIT_HIGH   | measuring a data bit's high pulse
// DONE       | frame presented, waiting for start_dht11 to drop
module dht11_reader
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned START_LOW_US  = 18000,
    parameter int unsigned BIT_THRESH_US = 50,
    parameter int unsigned TIMEOUT_US    = 200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_dht11,
    input  logic        dht_in,
    output logic        dht_drive_low,
    output logic [0:39] sensor_data,
    output logic        wait_dht11,
    output logic        error
);

    localparam int unsigned START_CYC   = us_to_cycles(CLK_HZ, START_LOW_US);
    localparam int unsigned THRESH_CYC  = us_to_cycles(CLK_HZ, BIT_THRESH_US);
    localparam int unsigned TIMEOUT_CYC = us_to_cycles(CLK_HZ, TIMEOUT_US);
    localparam int          CNT_W       = $clog2(START_CYC + 1);

    localparam logic [CNT_W-1:0] START_TC   = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(THRESH_CYC);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [0:39]      shreg_q, shreg_d;
    logic [0:39]      data_q, data_d;
    logic             error_q, error_d;
    logic             drive_q;
    logic             line_rise, line_fall;
    logic             in_wait_phase;

    dht11_sync_edge u_sync (
        .clk_i  (clock),
        .rst_i  (reset),
        .din_i  (dht_in),
        .rise_o (line_rise),
        .fall_o (line_fall)
    );

    assign in_wait_phase = (state_q == ST_RELEASE) || (state_q == ST_RESP_LOW) ||
                           (state_q == ST_RESP_HIGH) || (state_q == ST_BIT_LOW) ||
                           (state_q == ST_BIT_HIGH);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        error_d   = error_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_dht11) begin
                    state_d   = ST_START_LOW;
                    bit_cnt_d = '0;
                end
            end
            ST_START_LOW: begin
                if (cnt_q == START_TC) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE: begin
                if (line_fall) begin
                    state_d = ST_RESP_LOW;
                    cnt_d   = '0;
                end
            end
            ST_RESP_LOW: begin
                if (line_rise) begin
                    state_d = ST_RESP_HIGH;
                    cnt_d   = '0;
                end
            end
            ST_RESP_HIGH: begin
                if (line_fall) begin
                    state_d = ST_BIT_LOW;
                    cnt_d   = '0;
                end
            end
            ST_BIT_LOW: begin
                if (line_rise) begin
                    state_d = ST_BIT_HIGH;
                    cnt_d   = '0;
                end
            end
            ST_BIT_HIGH: begin
                if (line_fall) begin
                    // cnt_q excludes the falling-edge cycle, hence >= rather than >.
                    shreg_d = {shreg_q[1:39], (cnt_q >= THRESH_C)};
                    cnt_d   = '0;
                    if (bit_cnt_q == 6'd39) begin
                        state_d = ST_DONE;
                        data_d  = shreg_d;
                        error_d = 1'b0;
                    end else begin
                        state_d   = ST_BIT_LOW;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                cnt_d = '0;
                if (!start_dht11) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (in_wait_phase && (cnt_q == TIMEOUT_TC)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            data_d  = ERR_FRAME;
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            error_q   <= 1'b0;
            drive_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            error_q   <= error_d;
            drive_q   <= (state_d == ST_START_LOW);
        end
    end

    assign dht_drive_low = drive_q;
    assign sensor_data   = data_q;
    assign error         = error_q;
    assign wait_dht11    = ((state_q != ST_IDLE) && (state_q != ST_DONE)) ||
                           ((state_q == ST_IDLE) && start_dht11);

endmodule

// File: tb/tb_dht11_reader.sv
// Directed bench for dht11_reader: the bench plays the sensor on the shared line.
module tb_dht11_reader;

    // Shortened start pulse keeps the run small; all other timings are nominal.
    localparam int START_US = 2000;
    localparam logic [39:0] ERR_EXP = 40'h00_0000_00FF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sens  = 1'b1;
    logic        dht_in;
    logic        drv;
    logic        wt;
    logic        err;
    logic [0:39] data;

    int n_checks = 0;
    int n_errors = 0;

    assign dht_in = drv ? 1'b0 : sens;

    dht11_reader #(
        .CLK_HZ        (1_000_000),
        .START_LOW_US  (START_US),
        .BIT_THRESH_US (50),
        .TIMEOUT_US    (200)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start_dht11   (start),
        .dht_in        (dht_in),
        .dht_drive_low (drv),
        .sensor_data   (data),
        .wait_dht11    (wt),
        .error         (err)
    );

    always #500 clock = ~clock;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic begin_read(input string tag, output bit ok);
        int n;
        int len;
        @(negedge clock);
        start = 1'b1;
        #1;
        chk({tag, "_wait_raise"}, 40'(wt), 40'd1);
        n = 0;
        while (!drv && n < 5) begin
            @(negedge clock);
            n++;
        end
        if (!drv) begin
            chk({tag, "_drive_rise"}, 40'(drv), 40'd1);
            ok = 1'b0;
            return;
        end
        len = 0;
        while (drv && len < START_US + 10) begin
            len++;
            @(negedge clock);
        end
        chk({tag, "_drive_len"}, 40'(len), 40'(START_US));
        ok = 1'b1;
    endtask

    task automatic sensor_frame(input logic [39:0] frame, input int hi0, input int hi1,
                                input int stuck_bit, input int rst_bit, input string tag);
        int n;
        repeat (30) @(negedge clock);
        sens = 1'b0;
        repeat (80) @(negedge clock);
        sens = 1'b1;
        repeat (80) @(negedge clock);
        for (int i = 0; i < 40; i++) begin
            int w;
            sens = 1'b0;
            repeat (50) @(negedge clock);
            sens = 1'b1;
            if (i == rst_bit) begin
                repeat (10) @(negedge clock);
                reset = 1'b1;
                start = 1'b0;
                sens  = 1'b1;
                #1;
                chk({tag, "_rst_drive"}, 40'(drv), 40'd0);
                chk({tag, "_rst_wait"}, 40'(wt), 40'd0);
                chk({tag, "_rst_data"}, data, 40'd0);
                chk({tag, "_rst_err"}, 40'(err), 40'd0);
                @(negedge clock);
                reset = 1'b0;
                return;
            end
            w = (i == stuck_bit) ? 200 : (frame[39-i] ? hi1 : hi0);
            repeat (w) @(negedge clock);
            sens = 1'b0;
            if (i == stuck_bit) begin
                n = 0;
                while (wt && n < 20) begin
                    @(negedge clock);
                    n++;
                end
                chk({tag, "_stuck_done"}, 40'(wt), 40'd0);
                chk({tag, "_stuck_err"}, 40'(err), 40'd1);
                chk({tag, "_stuck_data"}, data, ERR_EXP);
                repeat (50) @(negedge clock);
                sens = 1'b1;
                return;
            end
        end
        repeat (3) @(negedge clock);
        chk({tag, "_wait_before_done"}, 40'(wt), 40'd1);
        @(negedge clock);
        chk({tag, "_wait_at_done"}, 40'(wt), 40'd0);
        chk({tag, "_err"}, 40'(err), 40'd0);
        chk({tag, "_data"}, data, frame);
        repeat (46) @(negedge clock);
        sens = 1'b1;
    endtask

    task automatic end_read();
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int viol;
        int n;

        repeat (3) @(negedge clock);
        chk("reset_drive", 40'(drv), 40'd0);
        chk("reset_wait", 40'(wt), 40'd0);
        chk("reset_data", data, 40'd0);
        chk("reset_err", 40'(err), 40'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        begin_read("normal", ok);
        if (ok) sensor_frame(40'h37_00_19_00_50, 26, 70, -1, -1, "normal");

        // start stays high after DONE: no second start pulse, no busy
        viol = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (drv || wt) viol++;
        end
        chk("rearm_hold", 40'(viol), 40'd0);
        end_read();

        begin_read("nosensor", ok);
        if (ok) begin
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (wt && n < 400);
            chk("nosensor_cycles", 40'(n), 40'd200);
            chk("nosensor_err", 40'(err), 40'd1);
            chk("nosensor_data", data, ERR_EXP);
            chk("nosensor_cksum", 40'(data[32:39]), 40'hFF);
        end
        end_read();

        begin_read("thresh", ok);
        if (ok) sensor_frame(40'hA5_5A_C3_3C_96, 50, 51, -1, -1, "thresh");
        end_read();

        begin_read("stuck", ok);
        if (ok) sensor_frame(40'h37_00_19_00_50, 26, 70, 3, -1, "stuck");
        end_read();

        begin_read("midrst", ok);
        if (ok) sensor_frame(40'h37_00_19_00_50, 26, 70, -1, 17, "midrst");
        repeat (3) @(negedge clock);

        begin_read("fresh", ok);
        if (ok) sensor_frame(40'h12_34_56_78_9A, 26, 70, -1, -1, "fresh");
        end_read();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
